// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial ripple adder: sum = a + b + cin, computed one bit per clock,
// LSB first, through a single full-adder cell and a carry flip-flop.
// Used as the low-area multi-cycle companion to the combinational add/sub
// cells. Feeding a=D, b=Y, cin=B_in recovers the minuend of a subtraction,
// which lets the datapath cross-check subtractor results.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 1)
//
// Ports
//   clk     in   1      system clock, rising edge
//   reset   in   1      synchronous, active-high reset
//   start   in   1      request; operands sampled on the edge where start=1
//                       and the adder is not busy
//   a       in   WIDTH  operand A
//   b       in   WIDTH  operand B
//   cin     in   1      carry-in
//   busy    out  1      high while bits are being computed
//   done    out  1      one-cycle pulse; sum/cout valid from this cycle
//   sum     out  WIDTH  result; holds until the next accepted start
//   cout    out  1      carry out of bit WIDTH-1; holds with sum
//   ovf     out  1      two's-complement overflow (OVERFLOW_DETECT_EN only)
//
// Build option
//   OVERFLOW_DETECT_EN  when defined, adds the ovf port and its flop.
//
// FSM states
//   state  | meaning
//   S_IDLE | waiting for start, last result visible on sum/cout
//   S_RUN  | one bit computed per edge, busy=1
//   S_DONE | result just published, done=1; start here begins a new op
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_DETECT_EN
  ,
  output logic             ovf
`endif
);

  // A 1-bit counter is still needed when WIDTH=1 ($clog2(1) is 0).
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_sh_nxt;
  logic             carry;
  logic             carry_nxt;
  logic             bit_s;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             accept;

  // ---------------------------------------------------------------------------
  // Full-adder cell and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    bit_s     = a_sh[0] ^ b_sh[0] ^ carry;
    carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    // New bit enters at the MSB; written as a shift of the concatenation so
    // the same expression also covers WIDTH=1 (result is just bit_s).
    s_sh_nxt  = WIDTH'({bit_s, s_sh} >> 1);
    last_bit  = (cnt == CNT_LAST);
    // start is honoured in IDLE and DONE, never while bits are in flight.
    accept    = start && (state != S_RUN);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (last_bit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (accept) begin
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from the registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand/result shift registers, carry, bit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= s_sh_nxt;
      carry <= carry_nxt;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Published result: only updated on the edge that enters DONE, so partial
  // bits never appear and the previous result stays visible while busy.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if ((state == S_RUN) && last_bit) begin
      sum  <= s_sh_nxt;
      cout <= carry_nxt;
    end
  end

`ifdef OVERFLOW_DETECT_EN
  // On the MSB cycle, carry holds the carry into the MSB and carry_nxt the
  // carry out of it; their difference flags signed overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if ((state == S_RUN) && last_bit) begin
      ovf <= carry ^ carry_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  logic         start1;
  logic         a1;
  logic         b1;
  logic         cin1;
  logic         busy1;
  logic         done1;
  logic         sum1;
  logic         cout1;

`ifdef OVERFLOW_DETECT_EN
  logic         ovf;
  logic         ovf1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // model of the currently published result
  logic [W-1:0] mdl_sum  = '0;
  logic         mdl_cout = 1'b0;
  logic         mdl_ovf  = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef OVERFLOW_DETECT_EN
    ,
    .ovf   (ovf)
`endif
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
`ifdef OVERFLOW_DETECT_EN
    ,
    .ovf   (ovf1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // plain arithmetic reference: {cout, sum}
  function automatic logic [W:0] ref_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic cv);
    int unsigned t;
    t = int'(av) + int'(bv) + int'(cv);
    return (W+1)'(t);
  endfunction

  // signed result out of range of a W-bit two's-complement number
  function automatic logic ref_ovf(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv);
    int s;
    s = int'($signed(av)) + int'($signed(bv)) + int'(cv);
    return (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
  endfunction

  task automatic check_result(input string tag);
    chk({tag, "_sum"}, 32'(sum), 32'(mdl_sum));
    chk({tag, "_cout"}, 32'(cout), 32'(mdl_cout));
`ifdef OVERFLOW_DETECT_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(mdl_ovf));
`endif
  endtask

  // One operation: start for one clock, watch latency/busy/hold, check result.
  // With mess=1, start and operands are scrambled while busy.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       input bit mess);
    logic [W:0] e;
    int cyc;
    int nbusy;
    bit held_ok;
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; nbusy = 0; held_ok = 1'b1;
    while (!done && cyc < 4*W + 8) begin
      if (busy) nbusy++;
      if (sum !== mdl_sum || cout !== mdl_cout) held_ok = 1'b0;
      if (mess) begin
        start = 1'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_latency", 32'(cyc), 32'(W + 1));
    chk("busy_cycles", 32'(nbusy), 32'(W));
    chk("hold_prev", 32'(held_ok), 32'd1);
    e = ref_add(av, bv, cv);
    mdl_sum  = e[W-1:0];
    mdl_cout = e[W];
    mdl_ovf  = ref_ovf(av, bv, cv);
    check_result("op");
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_d;
    int second_d;
    int nd;
    bit saw_done;
    logic [2:0] c3;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    check_result("rst");
    reset = 1'b0;

    // T1
    do_op(8'h25, 8'h1A, 1'b0, 1'b0);
    chk("t1_sum", 32'(sum), 32'h3F);
    // T2
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    chk("t2_wrap", 32'({cout, sum}), 32'h100);
    do_op(8'h3C, 8'h05, 1'b1, 1'b0);
    chk("t2_minuend", 32'(sum), 32'h42);
    // T6 overflow boundary cases
    do_op(8'h7F, 8'h01, 1'b0, 1'b0);
`ifdef OVERFLOW_DETECT_EN
    chk("t6_ovf_pos", 32'(ovf), 32'd1);
`endif
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
`ifdef OVERFLOW_DETECT_EN
    chk("t6_ovf_neg", 32'(ovf), 32'd0);
`endif

    // T3 back-to-back with start held high
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    first_d = -1; second_d = -1; nd = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (first_d < 0) first_d = i;
        else if (second_d < 0) second_d = i;
        chk("b2b_sum", 32'(sum), 32'h30);
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(nd), 32'd2);
    chk("b2b_spacing", 32'(second_d - first_d), 32'(W + 1));
    for (int i = 0; i < 40; i++) begin
      if (!busy && !done) break;
      @(negedge clk);
    end
    chk("b2b_drain", 32'(busy | done), 32'd0);
    mdl_sum = 8'h30; mdl_cout = 1'b0; mdl_ovf = 1'b0;
    check_result("b2b");

    // T4 reset mid-RUN
    do_op(8'h25, 8'h1A, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'h77; b = 8'h11; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mdl_sum = '0; mdl_cout = 1'b0; mdl_ovf = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    check_result("t4");
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("t4_no_done", 32'(saw_done), 32'd0);
    do_op(8'h77, 8'h11, 1'b1, 1'b0);

    // T5 + random: mixes clean and scrambled-while-busy operations
    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), bit'(i % 2));
    end

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      c3 = 3'(i);
      @(negedge clk);
      a1 = c3[2]; b1 = c3[1]; cin1 = c3[0]; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("w1_busy", 32'(busy1), 32'd1);
      @(negedge clk);
      chk("w1_done", 32'(done1), 32'd1);
      chk("w1_res", 32'({cout1, sum1}), 32'(int'(c3[2]) + int'(c3[1]) + int'(c3[0])));
`ifdef OVERFLOW_DETECT_EN
      // 1-bit signed range is {-1, 0}
      chk("w1_ovf", 32'(ovf1),
          32'((-int'(c3[2]) - int'(c3[1]) + int'(c3[0]) > 0) ||
              (-int'(c3[2]) - int'(c3[1]) + int'(c3[0]) < -1)));
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
